// File: rtl/fpu_issue_ctrl_if.sv
// Command and response handshake bundle between a requesting master and the
// FPU issue controller.
interface fpu_issue_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_out;
    logic [1:0]  rsp_op;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_out, rsp_op
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        output cmd_ready, rsp_valid, rsp_out, rsp_op
    );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// FPU issue controller: buffers {op, a, b} requests in a small FIFO, issues one
// at a time to a fixed-latency FPU, captures the result and returns it over a
// valid/ready response channel.
//
// state  | meaning
// IDLE   | nothing in flight; pop the FIFO head when one is buffered
// WAIT   | operands driven to the FPU, counting down its latency
// RESP   | result held on the response channel until consumed
module fpu_issue_ctrl #(
    parameter int DEPTH   = 4,
    parameter int LATENCY = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    fpu_issue_ctrl_if.slave       bus,
    output logic [1:0]            fpu_operation_o,
    output logic [31:0]           fpu_a_fpn_o,
    output logic [31:0]           fpu_b_fpn_o,
    input  logic [31:0]           fpu_out_i,
    output logic                  busy_o,
    output logic [15:0]           done_count_o
);

    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = AW + 1;
    localparam int CW   = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);
    localparam logic [CW-1:0]   LAT_LOAD = CW'(LATENCY);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    logic [65:0]     mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0] count_q;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      op_q, op_d;
    logic [31:0]     a_q, a_d;
    logic [31:0]     b_q, b_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [31:0]     rsp_out_q, rsp_out_d;
    logic [1:0]      rsp_op_q, rsp_op_d;
    logic [15:0]     done_q, done_d;

    logic            push;
    logic            pop;

    // Ready comes from the registered count only, so a same-cycle pop never frees a slot early.
    assign bus.cmd_ready = !rst_i && (count_q < FULL_CNT);
    assign push          = bus.cmd_valid && bus.cmd_ready;

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.cmd_op, bus.cmd_a, bus.cmd_b};
        end
    end

    // FIFO pointers and occupancy; push and pop in one cycle leave the count unchanged.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // State, latency counter, held operands and response registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_out_q   <= '0;
            rsp_op_q    <= '0;
            done_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_out_q   <= rsp_out_d;
            rsp_op_q    <= rsp_op_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic; the pop decision uses the pre-push count so a fresh push waits a cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_out_d   = rsp_out_q;
        rsp_op_d    = rsp_op_q;
        done_d      = done_q;
        pop         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop               = 1'b1;
                    {op_d, a_d, b_d}  = mem_q[rd_ptr_q];
                    cnt_d             = LAT_LOAD;
                    state_d           = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    rsp_out_d   = fpu_out_i;
                    rsp_op_d    = op_q;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_valid_q && bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    done_d      = done_q + 16'd1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_out     = rsp_out_q;
    assign bus.rsp_op      = rsp_op_q;
    assign fpu_operation_o = op_q;
    assign fpu_a_fpn_o     = a_q;
    assign fpu_b_fpn_o     = b_q;
    assign busy_o          = (state_q != S_IDLE) || (count_q != '0);
    assign done_count_o    = done_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: directed scenarios plus randomized traffic, checked
// against a transaction-level queue model and a registered FPU stand-in.
module tb_fpu_issue_ctrl;

    logic        clk;
    logic        rst;
    logic [1:0]  fpu_operation;
    logic [31:0] fpu_a_fpn;
    logic [31:0] fpu_b_fpn;
    logic [31:0] fpu_out;
    logic        busy;
    logic [15:0] done_count;

    fpu_issue_ctrl_if bus_if ();

    fpu_issue_ctrl #(.DEPTH(4), .LATENCY(1)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .bus             (bus_if),
        .fpu_operation_o (fpu_operation),
        .fpu_a_fpn_o     (fpu_a_fpn),
        .fpu_b_fpn_o     (fpu_b_fpn),
        .fpu_out_i       (fpu_out),
        .busy_o          (busy),
        .done_count_o    (done_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // FPU stand-in: known arithmetic results for the directed vectors, a mixing
    // function for everything else; one register stage gives LATENCY=1.
    function automatic logic [31:0] fpu_fn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [65:0] key;
        key = {op, a, b};
        case (key)
            {2'b00, 32'hC1C80000, 32'h41880000}: return 32'hC1000000;
            {2'b01, 32'h41900000, 32'h40400000}: return 32'h41700000;
            {2'b10, 32'h41A00000, 32'h40000000}: return 32'h42200000;
            {2'b11, 32'h41A00000, 32'h40000000}: return 32'h41200000;
            {2'b00, 32'hC1C80000, 32'hC1C80000}: return 32'hC2480000;
            default: return a ^ {b[15:0], b[31:16]} ^ (32'h9E3779B9 * {30'd0, op}) ^ 32'h5A5A0000;
        endcase
    endfunction

    always @(posedge clk) fpu_out <= fpu_fn(fpu_operation, fpu_a_fpn, fpu_b_fpn);

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } cmd_t;

    cmd_t        exp_q[$];
    logic [31:0] seen_q[$];
    int          rise_q[$];
    int          cyc = 0;
    logic [15:0] exp_done = 16'd0;
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [31:0] prev_out = 32'd0;
    logic [1:0]  prev_op = 2'd0;

    // Transaction model: outstanding commands in order; the edge that follows
    // each falling edge applies whatever handshakes are visible here.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            exp_done   = 16'd0;
            prev_valid = 1'b0;
        end else begin
            chk("done_count", 32'(done_count), 32'(exp_done));
            chk("busy", 32'(busy), 32'(exp_q.size() != 0));
            if (bus_if.rsp_valid) begin
                if (!prev_valid) rise_q.push_back(cyc);
                if (prev_valid && !prev_ready) begin
                    chk("hold_out", bus_if.rsp_out, prev_out);
                    chk("hold_op", 32'(bus_if.rsp_op), 32'(prev_op));
                end
                if (exp_q.size() == 0) begin
                    chk("spurious_rsp", 32'(bus_if.rsp_valid), 32'd0);
                end else begin
                    chk("rsp_out", bus_if.rsp_out, fpu_fn(exp_q[0].op, exp_q[0].a, exp_q[0].b));
                    chk("rsp_op", 32'(bus_if.rsp_op), 32'(exp_q[0].op));
                    if (bus_if.rsp_ready) begin
                        seen_q.push_back(bus_if.rsp_out);
                        void'(exp_q.pop_front());
                        exp_done = exp_done + 16'd1;
                    end
                end
            end
            prev_valid = bus_if.rsp_valid;
            prev_ready = bus_if.rsp_ready;
            prev_out   = bus_if.rsp_out;
            prev_op    = bus_if.rsp_op;
            if (bus_if.cmd_valid && bus_if.cmd_ready)
                exp_q.push_back('{op: bus_if.cmd_op, a: bus_if.cmd_a, b: bus_if.cmd_b});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_op    = op;
        bus_if.cmd_a     = a;
        bus_if.cmd_b     = b;
        while (!bus_if.cmd_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("send_timeout", 32'(bus_if.cmd_ready), 32'd1);
        tick();
        bus_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while ((busy || bus_if.rsp_valid) && n < bound) begin
            tick();
            n++;
        end
        if (n >= bound) chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    logic [31:0] exp_mix [4];
    cmd_t        bp_cmds [7];

    initial begin
        int n;
        int acc;
        int k;
        logic [31:0] held;
        logic [15:0] d0;
        logic        saw;

        rst              = 1'b1;
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_op    = 2'd0;
        bus_if.cmd_a     = 32'd0;
        bus_if.cmd_b     = 32'd0;
        bus_if.rsp_ready = 1'b0;

        // Reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready_low", 32'(bus_if.cmd_ready), 32'd0);
        rst = 1'b0;
        tick();
        chk("rst_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        chk("rst_rsp_out", bus_if.rsp_out, 32'd0);
        chk("rst_rsp_op", 32'(bus_if.rsp_op), 32'd0);
        chk("rst_fpu_op", 32'(fpu_operation), 32'd0);
        chk("rst_fpu_a", fpu_a_fpn, 32'd0);
        chk("rst_fpu_b", fpu_b_fpn, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done_count), 32'd0);

        // Single add with exact response latency
        send(2'b00, 32'hC1C80000, 32'h41880000);
        n = 0;
        while (!bus_if.rsp_valid && n < 20) begin
            tick();
            n++;
        end
        chk("add_latency", 32'(n), 32'd3);
        chk("add_out", bus_if.rsp_out, 32'hC1000000);
        chk("add_op", 32'(bus_if.rsp_op), 32'd0);
        chk("add_fpu_a_held", fpu_a_fpn, 32'hC1C80000);
        chk("add_fpu_b_held", fpu_b_fpn, 32'h41880000);
        bus_if.rsp_ready = 1'b1;
        tick();
        bus_if.rsp_ready = 1'b0;
        chk("add_done", 32'(done_count), 32'd1);

        // Mixed operations, in order
        bus_if.rsp_ready = 1'b1;
        seen_q.delete();
        send(2'b01, 32'h41900000, 32'h40400000);
        send(2'b10, 32'h41A00000, 32'h40000000);
        send(2'b11, 32'h41A00000, 32'h40000000);
        send(2'b00, 32'hC1C80000, 32'hC1C80000);
        wait_idle(100);
        exp_mix[0] = 32'h41700000;
        exp_mix[1] = 32'h42200000;
        exp_mix[2] = 32'h41200000;
        exp_mix[3] = 32'hC2480000;
        chk("mix_count", 32'(seen_q.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < seen_q.size()) chk("mix_result", seen_q[i], exp_mix[i]);

        // Backpressure and full FIFO
        bus_if.rsp_ready = 1'b0;
        seen_q.delete();
        for (int i = 0; i < 7; i++)
            bp_cmds[i] = '{op: 2'(i), a: 32'h3F800000 + 32'(i), b: $urandom};
        acc = 0;
        k   = 0;
        for (int c = 0; c < 10; c++) begin
            if (k < 7) begin
                bus_if.cmd_valid = 1'b1;
                bus_if.cmd_op    = bp_cmds[k].op;
                bus_if.cmd_a     = bp_cmds[k].a;
                bus_if.cmd_b     = bp_cmds[k].b;
                if (bus_if.cmd_ready) begin
                    acc++;
                    k++;
                end
            end else begin
                bus_if.cmd_valid = 1'b0;
            end
            tick();
        end
        chk("full_accepted", 32'(acc), 32'd5);
        chk("full_cmd_ready", 32'(bus_if.cmd_ready), 32'd0);
        bus_if.cmd_valid = 1'b0;
        chk("full_rsp_valid", 32'(bus_if.rsp_valid), 32'd1);
        held = bus_if.rsp_out;
        repeat (3) tick();
        chk("full_rsp_stable", bus_if.rsp_out, held);
        d0 = done_count;
        bus_if.rsp_ready = 1'b1;
        n = 0;
        while (!bus_if.cmd_ready && n < 20) begin
            tick();
            n++;
        end
        chk("full_ready_return", 32'(bus_if.cmd_ready), 32'd1);
        chk("full_ready_after_first", 32'(done_count), 32'(d0 + 16'd1));
        wait_idle(100);
        chk("full_count", 32'(seen_q.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            if (i < seen_q.size())
                chk("full_order", seen_q[i], fpu_fn(bp_cmds[i].op, bp_cmds[i].a, bp_cmds[i].b));

        // Reset while the first command is in WAIT
        bus_if.rsp_ready = 1'b1;
        send(2'b00, 32'h11111111, 32'h22222222);
        send(2'b01, 32'h33333333, 32'h44444444);
        send(2'b10, 32'h55555555, 32'h66666666);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus_if.rsp_valid) saw = 1'b1;
            tick();
        end
        chk("rstw_no_rsp", 32'(saw), 32'd0);
        chk("rstw_busy", 32'(busy), 32'd0);
        chk("rstw_done", 32'(done_count), 32'd0);
        seen_q.delete();
        send(2'b11, 32'h41A00000, 32'h40000000);
        wait_idle(50);
        chk("rstw_after_done", 32'(done_count), 32'd1);
        chk("rstw_after_count", 32'(seen_q.size()), 32'd1);
        if (seen_q.size() > 0) chk("rstw_after_out", seen_q[0], 32'h41200000);

        // Back-to-back throughput
        rise_q.delete();
        for (int i = 0; i < 4; i++) send(2'b00, $urandom, $urandom);
        wait_idle(100);
        chk("thru_count", 32'(rise_q.size()), 32'd4);
        for (int i = 1; i < 4; i++)
            if (i < rise_q.size()) chk("thru_gap", 32'(rise_q[i] - rise_q[i-1]), 32'd4);

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            bus_if.cmd_valid = 1'($urandom_range(0, 1));
            bus_if.cmd_op    = 2'($urandom_range(0, 3));
            bus_if.cmd_a     = $urandom;
            bus_if.cmd_b     = $urandom;
            bus_if.rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        bus_if.cmd_valid = 1'b0;
        bus_if.rsp_ready = 1'b1;
        wait_idle(300);
        chk("rand_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
